subbytes_pipe: RTL and testbench

SUBBYTES_PIPE -- requirements
Module: subbytes_pipe

---
 rtl/subbytes_pipe.sv | 153 +++++++++++++++
 tb/tb_subbytes_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/subbytes_pipe.sv
// subbytes_pipe: three-stage AES SubBytes engine over NUM_BYTES independent lanes.
// x^254 is built from the squaring chain x^2..x^128 and two partial-product stages.
// Inverse mode (InvSubBytes) exists only when SUBBYTES_INV_EN is defined.
// Without SUBBYTES_INV_EN, inv_i is ignored and every transfer uses the forward S-box.
module subbytes_pipe #(
    parameter int NUM_BYTES = 16,
    parameter int LANE_W    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [8*NUM_BYTES-1:0] in_data_i,
    input  logic                   inv_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [8*NUM_BYTES-1:0] out_data_o,
    output logic                   busy_o
);

    if (LANE_W != 8) begin : g_bad_lane_w
        $error("subbytes_pipe: LANE_W must be 8");
    end

    if (NUM_BYTES < 1 || NUM_BYTES > 16) begin : g_bad_num_bytes
        $error("subbytes_pipe: NUM_BYTES must be in 1..16");
    end

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (0x11B)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // Forward affine: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    function automatic logic [7:0] aff_fwd(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

`ifdef SUBBYTES_INV_EN
    // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
    function automatic logic [7:0] aff_inv(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    logic s1_inv;
    logic s2_inv;
`else
    logic unused_inv;
    assign unused_inv = inv_i;
`endif

    logic                               advance;
    logic                               s1_valid;
    logic                               s2_valid;
    logic [NUM_BYTES-1:0][6:0][7:0]     sq_d;
    logic [NUM_BYTES-1:0][6:0][7:0]     s1_sq;
    logic [NUM_BYTES-1:0][7:0]          pa_d;
    logic [NUM_BYTES-1:0][7:0]          pb_d;
    logic [NUM_BYTES-1:0][7:0]          s2_pa;
    logic [NUM_BYTES-1:0][7:0]          s2_pb;
    logic [8*NUM_BYTES-1:0]             out_d;

    // The whole pipe moves only when the output slot is free or being drained.
    assign advance    = !out_valid_o || out_ready_i;
    assign in_ready_o = advance;
    assign busy_o     = s1_valid || s2_valid || out_valid_o;

    // Stage 1 logic: optional pre-affine, then the squaring chain x^2..x^128 per lane.
    always_comb begin : p_s1
        logic [7:0] b;
        sq_d = '0;
        b    = 8'h00;
        for (int k = 0; k < NUM_BYTES; k++) begin
`ifdef SUBBYTES_INV_EN
            b = inv_i ? aff_inv(in_data_i[8*k +: 8]) : in_data_i[8*k +: 8];
`else
            b = in_data_i[8*k +: 8];
`endif
            sq_d[k][0] = gf_mul(b, b);
            for (int i = 1; i < 7; i++) begin
                sq_d[k][i] = gf_mul(sq_d[k][i-1], sq_d[k][i-1]);
            end
        end
    end

    // Stage 2 logic: split the seven-term product into two balanced partial products.
    always_comb begin : p_s2
        pa_d = '0;
        pb_d = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            pa_d[k] = gf_mul(gf_mul(s1_sq[k][6], s1_sq[k][5]), s1_sq[k][4]);
            pb_d[k] = gf_mul(gf_mul(s1_sq[k][3], s1_sq[k][2]),
                             gf_mul(s1_sq[k][1], s1_sq[k][0]));
        end
    end

    // Stage 3 logic: final multiply gives x^254, then forward affine unless inverse mode.
    always_comb begin : p_s3
        logic [7:0] prod;
        out_d = '0;
        prod  = 8'h00;
        for (int k = 0; k < NUM_BYTES; k++) begin
            prod = gf_mul(s2_pa[k], s2_pb[k]);
`ifdef SUBBYTES_INV_EN
            out_d[8*k +: 8] = s2_inv ? prod : aff_fwd(prod);
`else
            out_d[8*k +: 8] = aff_fwd(prod);
`endif
        end
    end

    // Valid bits and the output register: cleared asynchronously, shift together on advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
        end else if (advance) begin
            s1_valid    <= in_valid_i;
            s2_valid    <= s1_valid;
            out_valid_o <= s2_valid;
            if (s2_valid) out_data_o <= out_d;
        end
    end

    // Internal data registers carry no reset; they load only when a valid transfer moves in.
    always_ff @(posedge clk_i) begin
        if (advance && in_valid_i) begin
            s1_sq <= sq_d;
`ifdef SUBBYTES_INV_EN
            s1_inv <= inv_i;
`endif
        end
        if (advance && s1_valid) begin
            s2_pa <= pa_d;
            s2_pb <= pb_d;
`ifdef SUBBYTES_INV_EN
            s2_inv <= s1_inv;
`endif
        end
    end

endmodule

// File: tb/tb_subbytes_pipe.sv
// tb_subbytes_pipe: randomized and directed checks of subbytes_pipe against a table model.
// The model derives the S-box from a brute-force GF(2^8) inverse and the bitwise affine rule.
// Build with SUBBYTES_INV_EN defined to expect inverse results when inv=1.
module tb_subbytes_pipe;

    localparam int NB = 4;
`ifdef SUBBYTES_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          inv;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic [8*NB-1:0] in_data;
    logic [8*NB-1:0] out_data;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]      sbox  [256];
    logic [7:0]      isbox [256];
    logic [8*NB-1:0] exp_q [$];

    subbytes_pipe #(.NUM_BYTES(NB), .LANE_W(8)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .inv_i      (inv),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .busy_o     (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Carry-less product followed by polynomial reduction with 0x11B.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (acc[i]) acc = acc ^ (15'(9'h11B) << (i - 8));
        return acc[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] xv;
        logic [7:0] iv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            xv = 8'(x);
            iv = 8'h00;
            for (int y = 1; y < 256; y++) if (ref_mul(xv, 8'(y)) == 8'h01) iv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c[i];
            sbox[x]  = s;
            isbox[s] = xv;
        end
    endtask

    function automatic logic [8*NB-1:0] ref_out(input logic [8*NB-1:0] d, input logic m);
        logic [8*NB-1:0] r;
        r = '0;
        for (int k = 0; k < NB; k++)
            r[8*k +: 8] = (m && INV_EN) ? isbox[d[8*k +: 8]] : sbox[d[8*k +: 8]];
        return r;
    endfunction

    task automatic drive(input logic v, input logic [8*NB-1:0] d, input logic m, input logic r);
        in_valid  = v;
        in_data   = d;
        inv       = m;
        out_ready = r;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        compared++; if (out_data !== '0) begin mismatched++; $display("[TB] FAIL rst_out_data: got %h expected 0", out_data); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); end
        @(negedge clk) rst_n = 1'b1;
        #1;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL post_rst_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_vector(input string name, input logic [8*NB-1:0] d, input logic m,
                               input logic [8*NB-1:0] expv);
        @(negedge clk) drive(1'b1, d, m, 1'b1);
        #1;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL %s_in_ready: got %b expected 1", name, in_ready); end
        @(negedge clk) drive(1'b0, '0, 1'b0, 1'b1);
        #1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL %s_lat1: got %b expected 0", name, out_valid); end
        @(negedge clk) #1;
        compared++; if (out_valid !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("[TB] FAIL %s_lat2: got valid %b busy %b expected 0 1", name, out_valid, busy); end
        @(negedge clk) #1;
        compared++; if (out_valid !== 1'b1 || out_data !== expv) begin mismatched++; $display("[TB] FAIL %s_result: got %b/%h expected 1/%h", name, out_valid, out_data, expv); end
        @(negedge clk) #1;
        compared++; if (out_valid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL %s_drain: got valid %b busy %b expected 0 0", name, out_valid, busy); end
    endtask

    task automatic test_exhaustive(input int pattern);
        int              got;
        bit              gap;
        logic [7:0]      v;
        logic            m;
        logic [8*NB-1:0] e;
        got = 0;
        gap = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 259; i++) begin
            @(negedge clk);
            if (i < 256) begin
                v = 8'(i);
                m = (pattern == 2) ? 1'(i % 2) : 1'(pattern);
                drive(1'b1, {NB{v}}, m, 1'b1);
            end else begin
                drive(1'b0, '0, 1'b0, 1'b1);
            end
            #1;
            if ((i >= 3 && !out_valid) || (i < 256 && !in_ready)) gap = 1'b1;
            if (out_valid && out_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                compared++;
                if (out_data !== e) begin mismatched++; $display("[TB] FAIL exh%0d_data[%0d]: got %h expected %h", pattern, got, out_data, e); end
                got++;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_out(in_data, inv));
        end
        compared++; if (got != 256) begin mismatched++; $display("[TB] FAIL exh%0d_count: got %0d expected 256", pattern, got); end
        compared++; if (gap) begin mismatched++; $display("[TB] FAIL exh%0d_bubble: got gap 1 expected 0", pattern); end
    endtask

    task automatic test_backpressure();
        int              delivered;
        logic [8*NB-1:0] e;
        delivered = 0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i < 3)      drive(1'b1, $urandom(), 1'($urandom_range(0, 1)), 1'b1);
            else if (i < 8) drive(1'b1, $urandom(), 1'($urandom_range(0, 1)), 1'b0);
            else            drive(1'b0, '0, 1'b0, 1'b1);
            #1;
            if (i >= 3 && i < 8) begin
                compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
                compared++; if (out_valid !== 1'b1 || exp_q.size() == 0 || out_data !== exp_q[0]) begin mismatched++; $display("[TB] FAIL bp_hold[%0d]: got %b/%h expected held result", i, out_valid, out_data); end
            end
            if (out_valid && out_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                compared++;
                if (out_data !== e) begin mismatched++; $display("[TB] FAIL bp_data[%0d]: got %h expected %h", delivered, out_data, e); end
                delivered++;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_out(in_data, inv));
        end
        compared++; if (delivered != 3 || exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL bp_count: got %0d delivered expected 3", delivered); end
    endtask

    task automatic test_random(input int n);
        logic            prev_stall;
        logic [8*NB-1:0] prev_data;
        logic [8*NB-1:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        exp_q.delete();
        for (int i = 0; i < n + 12; i++) begin
            @(negedge clk);
            if (i < n) drive($urandom_range(0, 3) != 0, $urandom(), 1'($urandom_range(0, 1)),
                             $urandom_range(0, 9) < 7);
            else       drive(1'b0, '0, 1'b0, 1'b1);
            #1;
            compared++; if (in_ready !== (!out_valid || out_ready)) begin mismatched++; $display("[TB] FAIL rnd_in_ready[%0d]: got %b expected %b", i, in_ready, !out_valid || out_ready); end
            compared++; if (busy !== (exp_q.size() != 0)) begin mismatched++; $display("[TB] FAIL rnd_busy[%0d]: got %b expected %b", i, busy, exp_q.size() != 0); end
            if (prev_stall) begin
                compared++; if (out_valid !== 1'b1 || out_data !== prev_data) begin mismatched++; $display("[TB] FAIL rnd_stable[%0d]: got %b/%h expected 1/%h", i, out_valid, out_data, prev_data); end
            end
            if (out_valid && out_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                compared++;
                if (out_data !== e) begin mismatched++; $display("[TB] FAIL rnd_data[%0d]: got %h expected %h", i, out_data, e); end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready) exp_q.push_back(ref_out(in_data, inv));
        end
        compared++; if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL rnd_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        bit seen;
        seen = 1'b0;
        @(negedge clk) drive(1'b1, $urandom(), 1'b0, 1'b1);
        @(negedge clk) drive(1'b1, $urandom(), 1'b1, 1'b1);
        @(negedge clk) drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk) drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        compared++; if (out_valid !== 1'b1 || busy !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_inflight: got valid %b busy %b expected 1 1", out_valid, busy); end
        #1 rst_n = 1'b0;
        #1;
        compared++; if (out_valid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_drop: got valid %b busy %b expected 0 0", out_valid, busy); end
        compared++; if (out_data !== '0 || in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_rst_state: got data %h ready %b expected 0 1", out_data, in_ready); end
        exp_q.delete();
        @(posedge clk) #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk) drive(1'b0, '0, 1'b0, 1'b1);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        compared++; if (seen) begin mismatched++; $display("[TB] FAIL mid_ghost: got output after reset expected none"); end
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b1);
        build_tables();
        $display("[TB] starting, inverse mode %s", INV_EN ? "enabled" : "disabled");
        test_reset();
        test_vector("fwd_vec", 32'h53135700, 1'b0, 32'hED7D5B63);
`ifdef SUBBYTES_INV_EN
        test_vector("inv_vec", 32'hED7D5B63, 1'b1, 32'h53135700);
`else
        test_vector("inv_ignored", 32'h00000000, 1'b1, 32'h63636363);
`endif
        test_exhaustive(0);
        test_exhaustive(1);
        test_exhaustive(2);
        test_backpressure();
        test_random(300);
        test_reset_midflight();
        test_vector("post_reset", 32'hA53C00FF, 1'b0, ref_out(32'hA53C00FF, 1'b0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
